// File: rtl/video_dac_stage.sv
// Video DAC output stage: 2-stage sync/RGB pipeline with an hsync lock watchdog.
// Build option: define DAC_75PCT_EN for 75% gun level (4'hB) instead of full scale (4'hF).
module video_dac_stage #(
  parameter int LINE_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       display_on,
  input  logic [2:0] rgb_in,
  output logic [3:0] dac_r,
  output logic [3:0] dac_g,
  output logic [3:0] dac_b,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       blank_n,
  output logic       sync_lost,
  output logic [7:0] frame_count
);

`ifdef DAC_75PCT_EN
  localparam logic [3:0] ON_LEVEL = 4'hB;
`else
  localparam logic [3:0] ON_LEVEL = 4'hF;
`endif

  localparam logic [15:0] CNT_MAX = 16'(LINE_TIMEOUT - 1);

  generate
    if (LINE_TIMEOUT < 4 || LINE_TIMEOUT > 65535) begin : g_bad_timeout
      $error("LINE_TIMEOUT out of range 4..65535");
    end
  endgenerate

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       disp;
    logic [2:0] rgb;
  } stage_t;

  typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} state_t;

  stage_t      s1;
  logic        hs_prev, vs_prev;
  logic        h_edge, v_edge, timeout, lock_nxt;
  logic [15:0] wd_cnt;
  state_t      state, state_nxt;

  assign h_edge  = s1.hsync & ~hs_prev;
  assign v_edge  = s1.vsync & ~vs_prev;
  // An edge in the saturated cycle re-arms the watchdog instead of timing out.
  assign timeout = (wd_cnt == CNT_MAX) & ~h_edge;

  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH:  if (h_edge) state_nxt = CONFIRM;
      CONFIRM: if (h_edge) state_nxt = LOCKED;
               else if (timeout) state_nxt = SEARCH;
      LOCKED:  if (timeout) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
    lock_nxt = (state_nxt == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1          <= '0;
      hs_prev     <= 1'b0;
      vs_prev     <= 1'b0;
      wd_cnt      <= '0;
      state       <= SEARCH;
      frame_count <= '0;
      hsync_out   <= 1'b0;
      vsync_out   <= 1'b0;
      blank_n     <= 1'b0;
      sync_lost   <= 1'b1;
      dac_r       <= '0;
      dac_g       <= '0;
      dac_b       <= '0;
    end else begin
      s1      <= '{hsync: hsync_in, vsync: vsync_in, disp: display_on, rgb: rgb_in};
      hs_prev <= s1.hsync;
      vs_prev <= s1.vsync;

      if (h_edge)                wd_cnt <= '0;
      else if (wd_cnt != CNT_MAX) wd_cnt <= wd_cnt + 16'd1;

      state <= state_nxt;
      if (v_edge && state == LOCKED) frame_count <= frame_count + 8'd1;

      // s2: blanking and gun codes follow the lock state that becomes visible
      // on the same cycle, keeping them aligned with sync_lost.
      hsync_out <= s1.hsync;
      vsync_out <= s1.vsync;
      sync_lost <= ~lock_nxt;
      blank_n   <= s1.disp & lock_nxt;
      dac_r     <= (s1.disp & s1.rgb[2] & lock_nxt) ? ON_LEVEL : 4'h0;
      dac_g     <= (s1.disp & s1.rgb[1] & lock_nxt) ? ON_LEVEL : 4'h0;
      dac_b     <= (s1.disp & s1.rgb[0] & lock_nxt) ? ON_LEVEL : 4'h0;
    end
  end

endmodule

// File: tb/tb_video_dac_stage.sv
// Randomized bench for video_dac_stage against a gap/level reference model, plus directed literal checks.
module tb_video_dac_stage;
  localparam int LT = 1024;
`ifdef DAC_75PCT_EN
  localparam int ON = 11;
`else
  localparam int ON = 15;
`endif

  logic       clk = 0, reset = 0;
  logic       hsync_in = 0, vsync_in = 0, display_on = 0;
  logic [2:0] rgb_in = 0;
  logic [3:0] dac_r, dac_g, dac_b;
  logic       hsync_out, vsync_out, blank_n, sync_lost;
  logic [7:0] frame_count;

  video_dac_stage #(.LINE_TIMEOUT(LT)) dut (
    .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .display_on(display_on), .rgb_in(rgb_in), .dac_r(dac_r), .dac_g(dac_g),
    .dac_b(dac_b), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .blank_n(blank_n), .sync_lost(sync_lost), .frame_count(frame_count));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // stimulus configuration
  bit hen = 0, ven = 0;
  int hper = 800, hw = 8, hcnt = 0;
  int vper = 40, vw = 2, vcnt = 0, vleft = -1;
  int dmode = 0, rmode = 0;

  // reference model: input sample held one stage, integer lock level, unbounded line age
  bit   mvalid = 0;
  logic m_h, m_v, m_d, m_hp, m_vp;
  logic [2:0] m_rgb;
  int   m_age, m_lvl, m_fc;
  int   e_hs, e_vs, e_bl, e_sl, e_r, e_g, e_b;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic he, ve;
    int lvl0;
    if (reset) begin
      {m_hp, m_vp} = 0;
      m_age = 0; m_lvl = 0; m_fc = 0;
      {e_hs, e_vs, e_bl, e_r, e_g, e_b} = 0;
      e_sl = 1;
      mvalid = 1;
      {m_h, m_v, m_d, m_rgb} = 0;
    end else begin
      he = m_h && !m_hp;
      ve = m_v && !m_vp;
      lvl0 = m_lvl;
      // lock level counts consecutive edges spaced under LT cycles
      if (he) m_lvl = (m_lvl == 2) ? 2 : m_lvl + 1;
      else if (m_age >= LT - 1) m_lvl = 0;
      m_age = he ? 0 : m_age + 1;
      if (ve && lvl0 == 2) m_fc = (m_fc + 1) % 256;
      e_hs = m_h; e_vs = m_v;
      e_sl = (m_lvl == 2) ? 0 : 1;
      e_bl = (m_d && !e_sl) ? 1 : 0;
      e_r  = (e_bl && m_rgb[2]) ? ON : 0;
      e_g  = (e_bl && m_rgb[1]) ? ON : 0;
      e_b  = (e_bl && m_rgb[0]) ? ON : 0;
      m_hp = m_h; m_vp = m_v;
      m_h = hsync_in; m_v = vsync_in; m_d = display_on; m_rgb = rgb_in;
    end
  endtask

  task automatic compare_all();
    if (!mvalid) return;
    check("hsync_out", hsync_out, e_hs);
    check("vsync_out", vsync_out, e_vs);
    check("blank_n",   blank_n,   e_bl);
    check("sync_lost", sync_lost, e_sl);
    check("dac_r", dac_r, e_r);
    check("dac_g", dac_g, e_g);
    check("dac_b", dac_b, e_b);
    check("frame_count", frame_count, m_fc);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
    if (hen) begin
      hsync_in = (hcnt < hw);
      hcnt = (hcnt + 1 >= hper) ? 0 : hcnt + 1;
    end else hsync_in = 0;
    if (ven && vleft != 0) begin
      vsync_in = (vcnt < vw);
      if (vcnt == 0 && vleft > 0) vleft--;
      vcnt = (vcnt + 1 >= vper) ? 0 : vcnt + 1;
    end else vsync_in = 0;
    display_on = (dmode == 2) ? 1'($urandom) : (dmode == 1);
    rgb_in = (rmode < 0) ? 3'($urandom) : 3'(rmode);
  endtask

  task automatic do_reset(input int n);
    reset = 1;
    repeat (n) step();
    reset = 0;
  endtask

  task automatic start_h(input int per);
    hen = 1; hcnt = 0; hper = per; hw = 8;
  endtask

  int tog;
  logic last_vs;

  initial begin
    // reset state
    do_reset(3);
    check("rst_sync_lost", sync_lost, 1);
    check("rst_frame_count", frame_count, 0);
    check("rst_dac_r", dac_r, 0);
    check("rst_blank_n", blank_n, 0);

    // two hsync pulses 800 apart: lock appears 2 clk after second rising edge
    start_h(800);
    step();
    repeat (800) step();
    step();
    check("lock_after_1clk", sync_lost, 1);
    step();
    check("lock_after_2clk", sync_lost, 0);
    check("lock_frame_count", frame_count, 0);

    // bars 101
    dmode = 1; rmode = 5;
    repeat (3) step();
    check("bar_dac_r", dac_r, ON);
    check("bar_dac_g", dac_g, 0);
    check("bar_dac_b", dac_b, ON);
    check("bar_blank_n", blank_n, 1);

    // blanked region with all guns requested
    dmode = 0; rmode = 7;
    repeat (5) step();
    check("blank_dac_r", dac_r, 0);
    check("blank_dac_g", dac_g, 0);
    check("blank_blank_n", blank_n, 0);

    // randomized bursts: line periods straddle the timeout
    ven = 1; vper = 37; vw = 3; vleft = -1; dmode = 2; rmode = -1;
    repeat (3000) step();
    for (int b = 0; b < 5; b++) begin
      hen = 1; hcnt = 0;
      hper = $urandom_range(300, 1300);
      hw = $urandom_range(1, 20);
      vper = $urandom_range(5, 60);
      vw = $urandom_range(1, 4);
      repeat (2500) step();
    end

    // watchdog: stop hsync after one final edge
    start_h(800); ven = 0;
    repeat (1700) step();
    check("wd_locked", sync_lost, 0);
    dmode = 1; rmode = 7;
    ven = 1; vper = 40; vw = 20; vcnt = 0; vleft = -1;
    hen = 0;
    repeat (2) step();
    start_h(800);
    step();
    hen = 0;
    tog = 0; last_vs = vsync_out;
    for (int k = 1; k <= LT + 2; k++) begin
      step();
      if (vsync_out != last_vs) tog++;
      last_vs = vsync_out;
      if (k == LT + 1) check("wd_still_locked", sync_lost, 0);
      if (k == LT + 2) begin
        check("wd_lost", sync_lost, 1);
        check("wd_dac_r", dac_r, 0);
        check("wd_dac_b", dac_b, 0);
        check("wd_blank_n", blank_n, 0);
      end
    end
    check("wd_vsync_toggling", (tog > 0) ? 1 : 0, 1);
    start_h(500);
    step();
    repeat (500) step();
    repeat (2) step();
    check("relock_500", sync_lost, 0);

    // frame counter wrap: 257 vsync pulses locked, then 257 in SEARCH
    ven = 0; hen = 0;
    do_reset(2);
    start_h(800);
    repeat (810) step();
    check("fc_locked", sync_lost, 0);
    ven = 1; vper = 8; vw = 2; vcnt = 0; vleft = 257;
    repeat (257 * 8 + 10) step();
    check("fc_wrap", frame_count, 1);
    hen = 0;
    repeat (1100) step();
    check("fc_search", sync_lost, 1);
    vcnt = 0; vleft = 257;
    repeat (257 * 8 + 10) step();
    check("fc_hold_search", frame_count, 1);

    // reset mid active line
    ven = 0;
    start_h(800);
    repeat (810) step();
    dmode = 1; rmode = 7;
    repeat (100) step();
    check("pre_rst_dac_g", dac_g, ON);
    hen = 0;
    reset = 1;
    step();
    check("mid_rst_dac_r", dac_r, 0);
    check("mid_rst_dac_g", dac_g, 0);
    check("mid_rst_dac_b", dac_b, 0);
    check("mid_rst_blank_n", blank_n, 0);
    check("mid_rst_sync_lost", sync_lost, 1);
    reset = 0;
    repeat (2) step();
    start_h(400);
    step();
    repeat (10) step();
    check("one_edge_no_lock", sync_lost, 1);
    repeat (390) step();
    repeat (2) step();
    check("two_edges_lock", sync_lost, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
